// File: rtl/uart_link_ctrl.sv
// Control layer around the uart core: debounced button, host TX FIFO, transmit sequencer, RX capture.
// Define UART_LINK_DISP_EN to build the multiplexed 4-digit hex display instead of raw rx_data LEDs.
module uart_link_ctrl #(
   parameter logic [7:0] TX_BYTE         = 8'hCC,
   parameter int         TX_DEPTH        = 8,
   parameter int         DEBOUNCE_CYCLES = 50000,
   parameter int         SCAN_DIV        = 10000
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       ntransmit,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_overflow,
   output logic       busy,
   output logic       core_transmit,
   output logic [7:0] core_tx_byte,
   input  logic       core_is_transmitting,
   input  logic       core_received,
   input  logic [7:0] core_rx_byte,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [7:0] rx_count,
   output logic [7:0] led_disp,
   output logic [3:0] led_disp_cc
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_L = (AW + 1)'(TX_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state_q, state_d;

   logic          sync1_q, sync2_q, deb_q, deb_prev_q, pend_q;
   logic [CW-1:0] dcnt_q;
   logic [7:0]    mem_q [TX_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   cnt_q;
   logic          ovf_q, tx_q;
   logic [7:0]    txb_q;
   logic          rcv_q, rcv_prev_q, rxv_q;
   logic [7:0]    rcvb_q, rxd_q, rxc_q;

   logic       full, empty, push_req, push, pop;
   logic [7:0] push_data;

   assign full      = (cnt_q == DEPTH_L);
   assign empty     = (cnt_q == '0);
   assign push_req  = wr_en || pend_q;
   assign push_data = wr_en ? wr_data : TX_BYTE;
   assign push      = push_req && !full;
   assign pop       = (state_q == LOAD);

   // Debounced level idles high (button released); a falling edge queues one TX_BYTE.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         dcnt_q     <= '0;
         pend_q     <= 1'b0;
      end else begin
         sync1_q    <= ntransmit;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         if (sync2_q == deb_q) begin
            dcnt_q <= '0;
         end else if (dcnt_q == DB_LAST) begin
            deb_q  <= sync2_q;
            dcnt_q <= '0;
         end else begin
            dcnt_q <= dcnt_q + 1'b1;
         end
         // A cycle without wr_en always services the pending press: pushed or dropped.
         if (deb_prev_q && !deb_q) pend_q <= 1'b1;
         else if (!wr_en)          pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (push_req && full) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (!empty && !core_is_transmitting) state_d = LOAD;
         LOAD:      state_d = WAIT_BUSY;
         WAIT_BUSY: if (core_is_transmitting) state_d = WAIT_DONE;
         WAIT_DONE: if (!core_is_transmitting) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         tx_q    <= 1'b0;
         txb_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= pop;
         if (pop) txb_q <= mem_q[rd_ptr_q];
      end
   end

   // The strobe is registered once so a long-held strobe yields a single edge.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         rcv_q      <= 1'b0;
         rcv_prev_q <= 1'b0;
         rcvb_q     <= '0;
         rxv_q      <= 1'b0;
         rxd_q      <= '0;
         rxc_q      <= '0;
      end else begin
         rcv_q      <= core_received;
         rcvb_q     <= core_rx_byte;
         rcv_prev_q <= rcv_q;
         rxv_q      <= rcv_q && !rcv_prev_q;
         if (rcv_q && !rcv_prev_q) begin
            rxd_q <= rcvb_q;
            rxc_q <= rxc_q + 1'b1;
         end
      end
   end

   assign tx_full       = full;
   assign tx_empty      = empty;
   assign tx_overflow   = ovf_q;
   assign busy          = (state_q != IDLE);
   assign core_transmit = tx_q;
   assign core_tx_byte  = txb_q;
   assign rx_data       = rxd_q;
   assign rx_valid      = rxv_q;
   assign rx_count      = rxc_q;

`ifdef UART_LINK_DISP_EN
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [SW-1:0] scan_q;
   logic [1:0]    dig_q;
   logic [3:0]    nib;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         scan_q <= '0;
         dig_q  <= '0;
      end else if (scan_q == SCAN_LAST) begin
         scan_q <= '0;
         dig_q  <= dig_q + 1'b1;
      end else begin
         scan_q <= scan_q + 1'b1;
      end
   end

   always_comb begin
      nib      = '0;
      led_disp = 8'h00;
      unique case (dig_q)
         2'd0:    nib = rxd_q[3:0];
         2'd1:    nib = rxd_q[7:4];
         2'd2:    nib = rxc_q[3:0];
         default: nib = rxc_q[7:4];
      endcase
      led_disp_cc = ~(4'b0001 << dig_q);
      unique case (nib)
         4'h0: led_disp = 8'h3F;  4'h1: led_disp = 8'h06;
         4'h2: led_disp = 8'h5B;  4'h3: led_disp = 8'h4F;
         4'h4: led_disp = 8'h66;  4'h5: led_disp = 8'h6D;
         4'h6: led_disp = 8'h7D;  4'h7: led_disp = 8'h07;
         4'h8: led_disp = 8'h7F;  4'h9: led_disp = 8'h6F;
         4'hA: led_disp = 8'h77;  4'hB: led_disp = 8'h7C;
         4'hC: led_disp = 8'h39;  4'hD: led_disp = 8'h5E;
         4'hE: led_disp = 8'h79;  default: led_disp = 8'h71;
      endcase
   end
`else
   assign led_disp    = rxd_q;
   assign led_disp_cc = 4'b1110;
`endif
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_link_ctrl;
   localparam logic [7:0] TXB = 8'hCC;
   localparam int DEPTH = 4, DEB = 4, SDIV = 2, BUSY_LEN = 3;

   logic       clk = 1'b0, nrst = 1'b0, ntransmit = 1'b1, wr_en = 1'b0;
   logic [7:0] wr_data = '0, core_rx_byte = '0;
   logic       core_received = 1'b0, core_is_transmitting = 1'b0;
   logic       tx_full, tx_empty, tx_overflow, busy, core_transmit, rx_valid;
   logic [7:0] core_tx_byte, rx_data, rx_count, led_disp;
   logic [3:0] led_disp_cc;

   int checks = 0, errors = 0;

   uart_link_ctrl #(.TX_BYTE(TXB), .TX_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .nrst(nrst), .ntransmit(ntransmit), .wr_en(wr_en), .wr_data(wr_data),
      .tx_full(tx_full), .tx_empty(tx_empty), .tx_overflow(tx_overflow), .busy(busy),
      .core_transmit(core_transmit), .core_tx_byte(core_tx_byte),
      .core_is_transmitting(core_is_transmitting), .core_received(core_received),
      .core_rx_byte(core_rx_byte), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
      .led_disp(led_disp), .led_disp_cc(led_disp_cc));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Core stand-in: busy for BUSY_LEN cycles after each start pulse, or while hold is set.
   int         bcnt = 0;
   logic       hold = 1'b0;
   logic [7:0] tx_log [$];
   always @(negedge clk) begin
      if (core_transmit) begin
         bcnt = BUSY_LEN;
         tx_log.push_back(core_tx_byte);
      end else if (bcnt > 0) begin
         bcnt--;
      end
      core_is_transmitting = hold || (bcnt > 0);
   end

   // Reference model: FIFO as a queue, sequencer as a phase number, latencies from the rules.
   logic [7:0] mq [$];
   logic       m_started = 1'b0, m_ovf, m_ct, m_full, m_np, m_nd;
   int         m_ph, m_run, m_scan;
   logic [7:0] m_byte, m_pb, m_rxd, m_rxc;
   logic       m_s1, m_s2, m_deb, m_debp, m_pend, m_prevraw, m_due, m_rxv;

   always @(posedge clk) begin
      if (!nrst) begin
         mq.delete();
         m_ovf = 0; m_ct = 0; m_ph = 0; m_byte = 0;
         m_s1 = 1; m_s2 = 1; m_deb = 1; m_debp = 1; m_pend = 0; m_run = 0;
         m_prevraw = 0; m_due = 0; m_pb = 0; m_rxd = 0; m_rxc = 0; m_rxv = 0;
         m_scan = 0;
         m_started = 1;
      end else begin
         m_full = (mq.size() == DEPTH);
         m_rxv = m_due;
         if (m_due) begin
            m_rxd = m_pb;
            m_rxc = m_rxc + 8'd1;
         end
         m_due = core_received && !m_prevraw;
         m_pb = core_rx_byte;
         m_prevraw = core_received;
         m_ct = 0;
         case (m_ph)
            0: if (mq.size() != 0 && !core_is_transmitting) m_ph = 1;
            1: begin m_byte = mq.pop_front(); m_ct = 1; m_ph = 2; end
            2: if (core_is_transmitting) m_ph = 3;
            default: if (!core_is_transmitting) m_ph = 0;
         endcase
         if (wr_en || m_pend) begin
            if (m_full) m_ovf = 1;
            else mq.push_back(wr_en ? wr_data : TXB);
         end
         m_np = m_pend;
         if (!wr_en) m_np = 0;
         if (m_debp && !m_deb) m_np = 1;
         m_nd = m_deb;
         if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DEB) begin m_nd = m_s2; m_run = 0; end
         end else begin
            m_run = 0;
         end
         m_pend = m_np; m_debp = m_deb; m_deb = m_nd; m_s2 = m_s1; m_s1 = ntransmit;
         m_scan++;
      end
   end

   logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   int         e_dig;
   logic [3:0] e_nib;
   int         rxv_seen = 0;

   always @(negedge clk) begin
      if (m_started) begin
         if (rx_valid) rxv_seen++;
         chk("tx_full", tx_full, mq.size() == DEPTH);
         chk("tx_empty", tx_empty, mq.size() == 0);
         chk("tx_overflow", tx_overflow, m_ovf);
         chk("busy", busy, m_ph != 0);
         chk("core_transmit", core_transmit, m_ct);
         chk("core_tx_byte", core_tx_byte, m_byte);
         chk("rx_data", rx_data, m_rxd);
         chk("rx_valid", rx_valid, m_rxv);
         chk("rx_count", rx_count, m_rxc);
`ifdef UART_LINK_DISP_EN
         e_dig = (m_scan / SDIV) % 4;
         case (e_dig)
            0: e_nib = m_rxd[3:0];
            1: e_nib = m_rxd[7:4];
            2: e_nib = m_rxc[3:0];
            default: e_nib = m_rxc[7:4];
         endcase
         chk("led_disp", led_disp, SEG[e_nib]);
         chk("led_disp_cc", led_disp_cc, ~(4'b0001 << e_dig) & 4'hF);
`else
         chk("led_disp", led_disp, m_rxd);
         chk("led_disp_cc", led_disp_cc, 4'b1110);
`endif
      end
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while ((busy || !tx_empty || core_is_transmitting) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(nm, n < 60, 1'b1);
   endtask

   logic [7:0] pv [5]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
   logic [7:0] dled [4] = '{8'h71, 8'h06, 8'h5B, 8'h3F};
   logic [3:0] dcc [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   int base, rbase, n;

   initial begin
      nrst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_empty", tx_empty, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cc", led_disp_cc, 4'b1110);
`ifdef UART_LINK_DISP_EN
      chk("rst_led", led_disp, 8'h3F);
`else
      chk("rst_led", led_disp, 8'h00);
`endif

      // single host byte: start pulse two clocks after the push
      nrst = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
      @(negedge clk); wr_en = 1'b0;
      @(negedge clk); chk("t1_ct_early", core_transmit, 1'b0);
      @(negedge clk); chk("t1_ct", core_transmit, 1'b1); chk("t1_byte", core_tx_byte, 8'h55);
      @(negedge clk); chk("t1_ct_once", core_transmit, 1'b0); chk("t1_busy", busy, 1'b1);
      wait_idle("t1_idle");

      // bouncing button, then two clean presses
      base = tx_log.size();
      repeat (3) begin
         ntransmit = 1'b0; repeat (3) @(negedge clk);
         ntransmit = 1'b1; repeat (3) @(negedge clk);
      end
      chk("t2_bounce", tx_log.size() - base, 0);
      ntransmit = 1'b0; repeat (12) @(negedge clk);
      ntransmit = 1'b1; repeat (12) @(negedge clk);
      wait_idle("t2_idle1");
      chk("t2_one", tx_log.size() - base, 1);
      ntransmit = 1'b0; repeat (12) @(negedge clk);
      ntransmit = 1'b1; repeat (12) @(negedge clk);
      wait_idle("t2_idle2");
      chk("t2_two", tx_log.size() - base, 2);
      chk("t2_b0", tx_log[base], 8'hCC);
      chk("t2_b1", tx_log[base + 1], 8'hCC);

      // overflow while the core is held busy
      base = tx_log.size();
      hold = 1'b1; repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = pv[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
      chk("t3_full", tx_full, 1'b1);
      chk("t3_ovf", tx_overflow, 1'b1);
      hold = 1'b0;
      wait_idle("t3_idle");
      chk("t3_cnt", tx_log.size() - base, 4);
      for (int i = 0; i < 4; i++) chk("t3_order", tx_log[base + i], pv[i]);
      chk("t3_ovf_sticky", tx_overflow, 1'b1);

      // receive: long strobe counts once
      rbase = rxv_seen;
      core_rx_byte = 8'hA7; core_received = 1'b1; repeat (5) @(negedge clk);
      core_received = 1'b0; repeat (3) @(negedge clk);
      core_rx_byte = 8'h3C; core_received = 1'b1; repeat (2) @(negedge clk);
      core_received = 1'b0; repeat (3) @(negedge clk);
      chk("t4_pulses", rxv_seen - rbase, 2);
      chk("t4_count", rx_count, 8'h02);
      chk("t4_data", rx_data, 8'h3C);

      // reset in WAIT_DONE with a byte still queued
      wr_en = 1'b1; wr_data = 8'h66; @(negedge clk); wr_en = 1'b0;
      n = 0;
      while (!core_transmit && n < 20) begin @(negedge clk); n++; end
      chk("t5_start", n < 20, 1'b1);
      hold = 1'b1;
      wr_en = 1'b1; wr_data = 8'h77; @(negedge clk); wr_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_busy", busy, 1'b1);
      chk("t5_queued", tx_empty, 1'b0);
      base = tx_log.size();
      nrst = 1'b0; @(negedge clk);
      chk("t5_empty", tx_empty, 1'b1);
      chk("t5_busy0", busy, 1'b0);
      chk("t5_ovf0", tx_overflow, 1'b0);
      chk("t5_cnt0", rx_count, 8'h00);
      chk("t5_byte0", core_tx_byte, 8'h00);
      hold = 1'b0; nrst = 1'b1;
      repeat (8) @(negedge clk);
      chk("t5_no_tx", tx_log.size() - base, 0);

`ifdef UART_LINK_DISP_EN
      core_rx_byte = 8'h5A; core_received = 1'b1; @(negedge clk);
      core_received = 1'b0; repeat (2) @(negedge clk);
      core_rx_byte = 8'h1F; core_received = 1'b1; @(negedge clk);
      core_received = 1'b0; repeat (3) @(negedge clk);
      chk("t6_data", rx_data, 8'h1F);
      chk("t6_count", rx_count, 8'h02);
      n = 0;
      while (led_disp_cc != 4'b1110 && n < 20) begin @(negedge clk); n++; end
      for (int d = 0; d < 4; d++) begin
         chk("t6_led", led_disp, dled[d]);
         chk("t6_cc", led_disp_cc, dcc[d]);
         n = 0;
         while (led_disp_cc == dcc[d] && n < 20) begin @(negedge clk); n++; end
         chk("t6_scan", n < 20, 1'b1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
